tcp_vlg_tx_sched: RTL

//  Scheduler sharing one TCP tx engine between N_QUEUES tx queues (one per connection) and one control-segment source (pure ACK/FIN/RST).

---
 rtl/tcp_vlg_tx_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tcp_vlg_tx_sched.sv
// tcp_vlg_tx_sched
//   Shares one TCP tx engine between N_QUEUES per-connection tx queues and a
//   control-segment source (pure ACK/FIN/RST, no payload). One requester is
//   granted at a time. Its seq/len/checksum are latched and held for the
//   engine. The engine's payload reads are routed to the granted queue, and a
//   done pulse goes back to that queue. A watchdog aborts a grant that the
//   engine never completes.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   q_pending/seq/len/    per-queue request and packet descriptor (packed, queue i
//   q_chsum/q_data        at slice i), q_data is that queue's RAM read data
//   q_addr                payload read address broadcast to all queue RAMs
//   q_done                one-cycle completion pulse to the granted queue
//   ctl_req/ctl_done      control-segment request and completion pulse
//   tx_req/busy/done      handshake with the tx engine
//   tx_ctl/seq/len/chsum  latched descriptor presented to the engine
//   tx_addr/tx_d          engine payload read address and returned byte
//   abort                 one-cycle pulse when the watchdog expires
//   grant_id              current grant: 0..N_QUEUES-1 queue, N_QUEUES control
//
// state   | meaning
// S_IDLE  | arbitrate; the winner is captured on the way out
// S_LATCH | register the winner's descriptor, clear the watchdog
// S_REQ   | tx_req high until the engine shows tx_busy
// S_SEND  | engine transmitting, waiting for tx_done
// S_DONE  | done pulse to the granted requester, advance rr_ptr

module tcp_vlg_tx_sched #(
   parameter int N_QUEUES   = 4,
   parameter int RAM_DEPTH  = 10,
   parameter int TX_TIMEOUT = 4096,
   localparam int GW        = $clog2(N_QUEUES + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_QUEUES-1:0]     q_pending,
   input  logic [32*N_QUEUES-1:0]  q_seq,
   input  logic [16*N_QUEUES-1:0]  q_len,
   input  logic [32*N_QUEUES-1:0]  q_chsum,
   input  logic [8*N_QUEUES-1:0]   q_data,
   output logic [RAM_DEPTH-1:0]    q_addr,
   output logic [N_QUEUES-1:0]     q_done,
   input  logic                    ctl_req,
   output logic                    ctl_done,
   output logic                    tx_req,
   input  logic                    tx_busy,
   input  logic                    tx_done,
   output logic                    tx_ctl,
   output logic [31:0]             tx_seq,
   output logic [15:0]             tx_len,
   output logic [31:0]             tx_chsum,
   input  logic [RAM_DEPTH-1:0]    tx_addr,
   output logic [7:0]              tx_d,
   output logic                    abort,
   output logic [GW-1:0]           grant_id
);

   localparam int WW = $clog2(TX_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_REQ,
      S_SEND,
      S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [GW-1:0]  rr_ptr;
   logic [GW-1:0]  win_id;
   logic           win_ctl;
   logic [GW-1:0]  arb_id;
   logic           any_req;
   logic [WW-1:0]  wdog;
   logic           wdog_exp;
   logic           abort_r;
   logic           abort_nxt;
   logic [31:0]    lat_seq;
   logic [15:0]    lat_len;
   logic [31:0]    lat_chsum;

   // Round-robin pick: the pending queue at the smallest rotational distance
   // from rr_ptr wins. Control segments beat every queue.
   always_comb begin
      int best_d;
      int d;
      best_d  = N_QUEUES;
      d       = 0;
      arb_id  = GW'(N_QUEUES);
      any_req = ctl_req | (|q_pending);
      if (!ctl_req) begin
         for (int i = 0; i < N_QUEUES; i++) begin
            d = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + N_QUEUES - int'(rr_ptr));
            if (q_pending[i] && d < best_d) begin
               best_d = d;
               arb_id = GW'(i);
            end
         end
      end
   end

   // Descriptor of the captured winner. Control segments carry no payload.
   always_comb begin
      lat_seq   = '0;
      lat_len   = '0;
      lat_chsum = '0;
      if (!win_ctl) begin
         for (int i = 0; i < N_QUEUES; i++) begin
            if (win_id == GW'(i)) begin
               lat_seq   = q_seq[32*i +: 32];
               lat_len   = q_len[16*i +: 16];
               lat_chsum = q_chsum[32*i +: 32];
            end
         end
      end
   end

   assign wdog_exp = (wdog == WW'(TX_TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      abort_nxt = 1'b0;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_REQ;
         S_REQ: begin
            // A tx_done without a visible busy still completes the frame.
            if (tx_done) begin
               state_nxt = S_DONE;
            end else if (wdog_exp) begin
               state_nxt = S_DONE;
               abort_nxt = 1'b1;
            end else if (tx_busy) begin
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_done) begin
               state_nxt = S_DONE;
            end else if (wdog_exp) begin
               state_nxt = S_DONE;
               abort_nxt = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         win_id   <= '0;
         win_ctl  <= 1'b0;
         grant_id <= '0;
         tx_ctl   <= 1'b0;
         tx_seq   <= '0;
         tx_len   <= '0;
         tx_chsum <= '0;
         wdog     <= '0;
         abort_r  <= 1'b0;
      end else begin
         state   <= state_nxt;
         abort_r <= abort_nxt;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  win_id  <= arb_id;
                  win_ctl <= ctl_req;
               end
            end
            S_LATCH: begin
               wdog     <= '0;
               grant_id <= win_id;
               tx_ctl   <= win_ctl;
               tx_seq   <= lat_seq;
               tx_len   <= lat_len;
               tx_chsum <= lat_chsum;
            end
            S_REQ, S_SEND: wdog <= wdog + 1'b1;
            S_DONE: begin
               if (!tx_ctl) begin
                  rr_ptr <= (grant_id == GW'(N_QUEUES - 1)) ? '0 : grant_id + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_req   = (state == S_REQ);
   assign ctl_done = (state == S_DONE) && tx_ctl;
   assign abort    = abort_r;
   assign q_addr   = tx_addr;

   always_comb begin
      q_done = '0;
      tx_d   = '0;
      for (int i = 0; i < N_QUEUES; i++) begin
         if (grant_id == GW'(i)) begin
            q_done[i] = (state == S_DONE) && !tx_ctl;
            if (state != S_IDLE && !tx_ctl) tx_d = q_data[8*i +: 8];
         end
      end
   end

endmodule
